// File: rtl/mem_port.sv
// mem_port: single-request load/store port that maps a byte/half/word access onto one or two word beats.
// Define MEM_PORT_MISALIGNED_EN to accept unaligned accesses (word-crossing accesses use two beats).

module mem_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [23:0] hi_q;
    logic        err_q;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            2'd3:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    // Request acceptance is decided from the live inputs in the cycle req is sampled.
    logic accept_ok;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        accept_ok = (size != 2'd0);
`ifndef MEM_PORT_MISALIGNED_EN
        if (size == 2'd2 && addr[0])
            accept_ok = 1'b0;
        if (size == 2'd3 && addr[1:0] != 2'b00)
            accept_ok = 1'b0;
`endif
    end

    logic [1:0]  off;
    logic [3:0]  lane_mask;
    logic [7:0]  s64;
    logic [63:0] d64;
    logic [31:0] word_addr;
    logic [31:0] byte_mask;
    logic [31:0] lane_val;
    logic        need_beat1;

    assign off        = addr_q[1:0];
    assign lane_mask  = size_mask(size_q);
    assign s64        = {4'd0, lane_mask} << off;
    assign d64        = {32'd0, wdata_q} << {off, 3'b000};
    assign need_beat1 = |s64[7:4];
    assign word_addr  = {addr_q[31:2], 2'b00};
    assign byte_mask  = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};

    // Right-align the loaded bytes out of the {hi, lo} pair; hi never contributes above byte 2.
    always_comb begin
        case (off)
            2'd0:    lane_val = lo_q;
            2'd1:    lane_val = {hi_q[7:0],  lo_q[31:8]};
            2'd2:    lane_val = {hi_q[15:0], lo_q[31:16]};
            default: lane_val = {hi_q[23:0], lo_q[31:24]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (req)     state_nxt = accept_ok ? BEAT0 : FIN;
            BEAT0: if (bus_ack) state_nxt = need_beat1 ? BEAT1 : FIN;
            BEAT1: if (bus_ack) state_nxt = FIN;
            FIN:                state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // Bus outputs decode straight from state so reset drops them without waiting for a clock.
    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 32'd0;
        bus_wstrb = 4'h0;
        bus_wdata = 32'd0;
        case (state)
            BEAT0: begin
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = word_addr;
                bus_wstrb = we_q ? s64[3:0] : 4'h0;
                bus_wdata = d64[31:0];
            end
            BEAT1: begin
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = word_addr + 32'd4;
                bus_wstrb = we_q ? s64[7:4] : 4'h0;
                bus_wdata = d64[63:32];
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: request and capture registers are reset too, keeping outputs defined before the first access.
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            lo_q    <= 32'd0;
            hi_q    <= 24'd0;
            err_q   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            done <= (state == FIN);
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        lo_q    <= 32'd0;
                        hi_q    <= 24'd0;
                        err_q   <= !accept_ok;
                    end
                end
                BEAT0: if (bus_ack) lo_q <= bus_rdata;
                BEAT1: if (bus_ack) hi_q <= bus_rdata[23:0];
                FIN: begin
                    err   <= err_q;
                    rdata <= (err_q || we_q) ? 32'd0 : (lane_val & byte_mask);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed cases plus randomized accesses against a byte-level reference model.
// Honours MEM_PORT_MISALIGNED_EN the same way the design does.

module tb_mem_port;

`ifdef MEM_PORT_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk, rst_n, req, we, bus_ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, bus_rdata;
    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    mem_port dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one access starting at a negedge with the port idle; ends at a negedge with the port idle.
    // The reference model works byte by byte: byte j of the access lives at address addr+j.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input int waits,
                             input logic [31:0] rd0, input logic [31:0] rd1, input bit noise,
                             output logic [31:0] got_rd, output logic got_err);
        logic [31:0] exp_addr [2];
        logic [3:0]  exp_strb [2];
        logic [31:0] exp_wd   [2];
        logic [31:0] rdw      [2];
        logic [31:0] base, lastb, ba, exp_rd;
        int          nbytes, nb, bt;
        bit          rej;

        rdw[0] = rd0;
        rdw[1] = rd1;
        nbytes = (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
        rej    = (sz == 2'd0) ||
                 (!MIS_EN && ((sz == 2'd2 && a[0]) || (sz == 2'd3 && a[1:0] != 2'b00)));
        base   = {a[31:2], 2'b00};
        lastb  = a + 32'(nbytes - 1);
        nb     = ({lastb[31:2], 2'b00} != base) ? 2 : 1;
        for (int b = 0; b < 2; b++) begin
            exp_addr[b] = base + 32'(4 * b);
            exp_strb[b] = 4'h0;
            exp_wd[b]   = 32'd0;
            for (int l = 0; l < 4; l++) begin
                int j;
                j = 4 * b + l - int'(a[1:0]);
                if (j >= 0 && j < 4)
                    exp_wd[b][8*l +: 8] = wd[8*j +: 8];
                if (w && j >= 0 && j < nbytes)
                    exp_strb[b][l] = 1'b1;
            end
        end
        exp_rd = 32'd0;
        if (!rej && !w) begin
            for (int j = 0; j < nbytes; j++) begin
                ba = a + 32'(j);
                bt = ({ba[31:2], 2'b00} != base) ? 1 : 0;
                exp_rd[8*j +: 8] = rdw[bt][8*int'(ba[1:0]) +: 8];
            end
        end

        req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        if (noise) begin
            req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom;
        end

        if (!rej) begin
            for (int b = 0; b < nb; b++) begin
                for (int c = 0; c <= waits; c++) begin
                    check("beat_req",   32'(bus_req),   32'd1);
                    check("beat_we",    32'(bus_we),    32'(w));
                    check("beat_addr",  bus_addr,       exp_addr[b]);
                    check("beat_wstrb", 32'(bus_wstrb), 32'(exp_strb[b]));
                    if (w) check("beat_wdata", bus_wdata, exp_wd[b]);
                    check("beat_busy",  32'(busy),      32'd1);
                    check("beat_done",  32'(done),      32'd0);
                    bus_ack   = (c == waits);
                    bus_rdata = (c == waits) ? rdw[b] : $urandom;
                    @(negedge clk);
                    if (noise) req = 1'($urandom_range(0, 1));
                end
            end
        end

        check("fin_busy", 32'(busy),    32'd1);
        check("fin_done", 32'(done),    32'd0);
        check("fin_req",  32'(bus_req), 32'd0);
        bus_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus_rdata = $urandom;
        @(negedge clk);

        check("done",       32'(done),    32'd1);
        check("done_err",   32'(err),     32'(rej));
        check("done_rdata", rdata,        exp_rd);
        check("done_busy",  32'(busy),    32'd0);
        check("done_req",   32'(bus_req), 32'd0);
        got_rd  = rdata;
        got_err = err;
        req = 1'b0;
        bus_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);

        check("post_done",  32'(done),    32'd0);
        check("post_req",   32'(bus_req), 32'd0);
        check("post_busy",  32'(busy),    32'd0);
        check("hold_rdata", rdata,        exp_rd);
        check("hold_err",   32'(err),     32'(rej));
        bus_ack = 1'b0;
    endtask

    logic [31:0] got_rd, tmp, rd_lo, rd_hi, ra;
    logic        got_err;

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
        bus_rdata = 32'd0; bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_rdata", rdata,          32'd0);
        check("rst_req",   32'(bus_req),   32'd0);
        check("rst_we",    32'(bus_we),    32'd0);
        check("rst_addr",  bus_addr,       32'd0);
        check("rst_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_wdata", bus_wdata,      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned word load, immediate ack.
        do_access(1'b0, 2'd3, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF, 32'd0, 1'b0, got_rd, got_err);
        check("lw_rdata", got_rd, 32'hDEAD_BEEF);
        check("lw_err",   32'(got_err), 32'd0);

        // Byte store into the top lane.
        do_access(1'b1, 2'd1, 32'h0000_0203, 32'h0000_00A5, 0, 32'd0, 32'd0, 1'b0, got_rd, got_err);
        check("sb_err", 32'(got_err), 32'd0);

        // Word-crossing half load with three wait cycles per beat.
        tmp   = $urandom;
        rd_lo = {8'h11, tmp[23:0]};
        tmp   = $urandom;
        rd_hi = {tmp[31:8], 8'h22};
        do_access(1'b0, 2'd2, 32'h0000_0007, 32'd0, 3, rd_lo, rd_hi, 1'b0, got_rd, got_err);
        check("lh_x_rdata", got_rd,       MIS_EN ? 32'h0000_2211 : 32'd0);
        check("lh_x_err",   32'(got_err), MIS_EN ? 32'd0 : 32'd1);

        // Word store crossing the top of the address space.
        do_access(1'b1, 2'd3, 32'hFFFF_FFFE, 32'h1122_3344, 1, 32'd0, 32'd0, 1'b0, got_rd, got_err);
        check("sw_wrap_err", 32'(got_err), MIS_EN ? 32'd0 : 32'd1);

        // Size 0 is always rejected.
        do_access(1'b0, 2'd0, 32'h0000_0040, 32'd0, 0, 32'd0, 32'd0, 1'b0, got_rd, got_err);
        check("sz0_err", 32'(got_err), 32'd1);

        // Reset while a beat waits for ack.
        req = 1'b1; we = 1'b0; size = 2'd3; addr = 32'h0000_0040;
        @(negedge clk);
        req = 1'b0; bus_ack = 1'b0;
        check("mid_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req",  32'(bus_req), 32'd0);
        check("mid_rst_busy", 32'(busy),    32'd0);
        check("mid_rst_addr", bus_addr,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_nodone", 32'(done), 32'd0);
        end
        do_access(1'b0, 2'd3, 32'h0000_0080, 32'd0, 0, 32'hCAFE_F00D, 32'd0, 1'b0, got_rd, got_err);
        check("after_rst_rdata", got_rd, 32'hCAFE_F00D);

        // Randomized accesses with req pulses while busy and stray acks.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) == 0)
                ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom,
                      $urandom_range(0, 3), $urandom, $urandom, 1'b1, got_rd, got_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
